// File: rtl/program_counter_ras.sv
// Program counter with a circular return-address stack.
// Each enabled, unstalled cycle the PC takes exactly one action. The
// priority order is clear, return, branch, register jump, relative jump,
// then increment. A call on a register or relative jump pushes PC+INSTR_BYTES.
// When the stack is full, a push overwrites the oldest entry.
module program_counter_ras #(
  parameter int                  PC_WIDTH      = 16,
  parameter int                  INSTR_BYTES   = 2,
  parameter int                  BR_IMM_WIDTH  = 6,
  parameter int                  JMP_IMM_WIDTH = 12,
  parameter int                  RAS_DEPTH     = 4,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR  = '0
) (
  input  logic                               clk_pi,
  input  logic                               reset_n_pi,
  input  logic                               clk_en_pi,
  input  logic                               sync_clear_pi,
  input  logic                               stall_pi,
  input  logic                               branch_taken_pi,
  input  logic [BR_IMM_WIDTH-1:0]            branch_immediate_pi,
  input  logic                               jump_taken_pi,
  input  logic [JMP_IMM_WIDTH-1:0]           jump_immediate_pi,
  input  logic                               jump_reg_pi,
  input  logic [PC_WIDTH-1:0]                jump_target_pi,
  input  logic                               call_pi,
  input  logic                               return_pi,
  output logic [PC_WIDTH-1:0]                pc_po,
  output logic [PC_WIDTH-1:0]                pc_plus_po,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count_po,
  output logic                               ras_overflow_po,
  output logic                               ras_underflow_po
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(INSTR_BYTES - 1));

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    ras_count_q, ras_count_d;
  // Points at the slot the next push writes; the top of stack is one below.
  logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  logic                       push_en;
  logic [PTR_W-1:0]           top_idx;
  logic [PC_WIDTH-1:0]        pc_plus;
  logic signed [BR_IMM_WIDTH-1:0]  br_imm_s;
  logic signed [JMP_IMM_WIDTH-1:0] jmp_imm_s;
  logic [PC_WIDTH-1:0]        br_off;
  logic [PC_WIDTH-1:0]        jmp_off;

  assign pc_plus   = pc_q + PC_STEP;
  assign top_idx   = (ras_ptr_q == '0) ? PTR_LAST : ras_ptr_q - 1'b1;
  assign br_imm_s  = branch_immediate_pi;
  assign jmp_imm_s = jump_immediate_pi;
  // Sizing casts of signed operands sign-extend the offsets to PC width.
  assign br_off    = PC_WIDTH'(br_imm_s);
  assign jmp_off   = PC_WIDTH'(jmp_imm_s);

  // Select the single PC action for this cycle and update the stack bookkeeping.
  always_comb begin
    pc_d        = pc_q;
    ras_count_d = ras_count_q;
    ras_ptr_d   = ras_ptr_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_en     = 1'b0;
    if (clk_en_pi) begin
      if (sync_clear_pi) begin
        pc_d        = RESET_VECTOR;
        ras_count_d = '0;
        ras_ptr_d   = '0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
      end else if (!stall_pi) begin
        if (return_pi) begin
          if (ras_count_q != '0) begin
            pc_d        = ras_mem_q[top_idx];
            ras_count_d = ras_count_q - 1'b1;
            ras_ptr_d   = top_idx;
          end else begin
            pc_d  = pc_plus;
            unf_d = 1'b1;
          end
        end else if (branch_taken_pi) begin
          pc_d = pc_plus + br_off;
        end else if (jump_reg_pi) begin
          pc_d    = jump_target_pi & ALIGN_MASK;
          push_en = call_pi;
        end else if (jump_taken_pi) begin
          pc_d    = pc_plus + jmp_off;
          push_en = call_pi;
        end else begin
          pc_d = pc_plus;
        end
        if (push_en) begin
          ras_ptr_d = (ras_ptr_q == PTR_LAST) ? '0 : ras_ptr_q + 1'b1;
          if (ras_count_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            ras_count_d = ras_count_q + 1'b1;
          end
        end
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      pc_q        <= RESET_VECTOR;
      ras_count_q <= '0;
      ras_ptr_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ras_count_q <= ras_count_d;
      ras_ptr_q   <= ras_ptr_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Stack storage is not reset; entries beyond the count are never read.
  always_ff @(posedge clk_pi) begin
    if (push_en) begin
      ras_mem_q[ras_ptr_q] <= pc_plus;
    end
  end

  assign pc_po            = pc_q;
  assign pc_plus_po       = pc_plus;
  assign ras_count_po     = ras_count_q;
  assign ras_overflow_po  = ovf_q;
  assign ras_underflow_po = unf_q;

endmodule

// File: doc/program_counter_ras.md
PROGRAM_COUNTER_RAS -- requirements
Module: program_counter_ras

Interface
REQ-001 SHALL provide parameter PC_WIDTH, default 16: width of the PC, the targets and the stack entries.
REQ-002 SHALL provide parameter INSTR_BYTES, default 2: increment per instruction; power of two, at least 1.
REQ-003 SHALL provide parameter BR_IMM_WIDTH, default 6: branch offset width, signed.
REQ-004 SHALL provide parameter JMP_IMM_WIDTH, default 12: jump offset width, signed.
REQ-005 SHALL provide parameter RAS_DEPTH, default 4: return-address stack entries, at least 2.
REQ-006 SHALL provide parameter RESET_VECTOR, default 0: PC value after any reset or clear.
REQ-007 clk_pi  in  1  single clock; all state updates on its rising edge.
REQ-008 reset_n_pi  in  1  asynchronous, active-low reset.
REQ-009 clk_en_pi  in  1  global enable; when 0, no state changes.
REQ-010 sync_clear_pi  in  1  synchronous clear of PC, stack and flags.
REQ-011 stall_pi  in  1  hold the PC and stack this cycle.
REQ-012 branch_taken_pi  in  1 / branch_immediate_pi  in  BR_IMM_WIDTH  relative branch request and its offset.
REQ-013 jump_taken_pi  in  1 / jump_immediate_pi  in  JMP_IMM_WIDTH  relative jump request and its offset.
REQ-014 jump_reg_pi  in  1 / jump_target_pi  in  PC_WIDTH  absolute (register) jump request and its target.
REQ-015 call_pi  in  1  qualifies a jump or register jump as a call; pushes the return address.
REQ-016 return_pi  in  1  pops the stack and jumps to the popped address.
REQ-017 pc_po  out  PC_WIDTH  current PC, registered.
REQ-018 pc_plus_po  out  PC_WIDTH  combinational PC + INSTR_BYTES.
REQ-019 ras_count_po  out  clog2(RAS_DEPTH+1)  number of valid stack entries.
REQ-020 ras_overflow_po / ras_underflow_po  out  1 each  sticky error flags.

Function
REQ-021 Each enabled, unstalled cycle SHALL apply exactly one PC action, chosen in this priority order:
- sync_clear
- return
- branch
- register jump
- relative jump
- increment
REQ-022 Increment action SHALL set PC to PC + INSTR_BYTES.
REQ-023 Branch action SHALL set PC to PC + INSTR_BYTES + sign_extend(branch_immediate_pi) to PC_WIDTH.
REQ-024 Relative jump action SHALL set PC to PC + INSTR_BYTES + sign_extend(jump_immediate_pi) to PC_WIDTH.
REQ-025 Register jump action SHALL set PC to jump_target_pi with its low log2(INSTR_BYTES) bits forced to 0.
REQ-026 All PC arithmetic SHALL be modulo 2^PC_WIDTH; wrap-around is silent, with no flag.
REQ-027 When call_pi is high and the selected action is a register jump or relative jump, the block SHALL push PC + INSTR_BYTES.
REQ-028 call_pi SHALL be ignored when it accompanies a branch, return or increment action.
REQ-029 Return action with count > 0 SHALL:
- set PC to the top entry;
- decrement the count.
REQ-030 Return action with count = 0 SHALL:
- set ras_underflow_po;
- set PC to PC + INSTR_BYTES;
- leave the stack unchanged.
REQ-031 A push at count = RAS_DEPTH SHALL:
- overwrite the oldest entry (circular stack);
- hold the count at RAS_DEPTH;
- set ras_overflow_po.
REQ-032 A return that is simultaneous with call_pi SHALL pop only; no push occurs.
REQ-033 When stall_pi = 1 or clk_en_pi = 0, the PC, stack, count and flags SHALL hold.
REQ-034 sync_clear_pi SHALL act only when clk_en_pi = 1, and SHALL override stall_pi.
REQ-035 Flags SHALL stay set until reset or sync_clear.
REQ-036 Flags SHALL never clear the stack contents by themselves.
REQ-037 All outputs except pc_plus_po SHALL be registered.
REQ-038 Request-to-pc_po latency SHALL be one cycle.

Reset
REQ-039 reset_n_pi = 0 SHALL immediately, without waiting for a clock edge:
- set PC to RESET_VECTOR;
- set the count to 0;
- clear both flags.
REQ-040 Release of reset SHALL be sampled synchronously; the first update occurs on the first enabled edge with reset_n_pi = 1.
REQ-041 Asserting reset mid-call or mid-return SHALL discard the in-flight push or pop.
REQ-042 Stack entry contents after reset are don't-care, because the count is 0.
REQ-043 sync_clear SHALL produce the same state as reset, at the clock edge.

Verification
REQ-044 Reset, then 3 enabled cycles -> pc_po = 0x0000, 0x0002, 0x0004, 0x0006; a stalled cycle holds 0x0006.
REQ-045 At PC = 0x0010: branch with imm 6'b111110 (-2) -> 0x0010.
- Same cycle with a jump of +8 also asserted -> branch wins.
- Relative jump alone with imm +8 -> 0x001A.
REQ-046 PC = 0x0100: call via register jump to 0x2001 -> PC = 0x2000, count = 1.
- Then return -> PC = 0x0102, count = 0.
REQ-047 Five calls with RAS_DEPTH = 4 -> count = 4, ras_overflow_po = 1.
- Four returns -> the last four return addresses pop in LIFO order.
- A fifth return -> ras_underflow_po = 1 and PC increments.
REQ-048 Wrap-around and enable:
- PC = 0xFFFE, increment -> 0x0000, no flag.
- PC = 0x0004, jump imm 12'hFFA (-6) -> 0x0000.
- clk_en_pi = 0 with any requests -> no change.
REQ-049 Reset pulsed asynchronously between clock edges while call_pi is high -> pc_po = RESET_VECTOR at once, count = 0, flags = 0.
